// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: one shared period counter, per-channel compare lanes, TOP/CMP/MODE held
// in shadow registers until the period boundary. Define PWM_CENTER_EN to build centre-aligned mode.

module pwm_chan #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             xfer_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             out_o
);
    logic [WIDTH-1:0] cmp_sh_q, cmp_act_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_sh_q  <= '0;
            cmp_act_q <= '0;
        end else begin
            if (xfer_i) cmp_act_q <= cmp_sh_q;
            if (wr_i)   cmp_sh_q  <= wdata_i;
        end
    end

    assign out_o = (cnt_i < cmp_act_q);
endmodule

module pwm_multi_channel #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int AW       = $clog2(CHANNELS + 3)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                wr,
    input  logic [AW-1:0]       addr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    cnt,
    output logic [CHANNELS-1:0] out,
    output logic                period_end
);
    localparam logic [AW-1:0] A_TOP = AW'(0);
    localparam logic [AW-1:0] A_CNT = AW'(1);

    logic [WIDTH-1:0]    cnt_q, cnt_d, top_sh_q, top_act_q;
    logic                cnt_wr, top_wr, boundary;
    logic [CHANNELS-1:0] cmp_wr;

    assign cnt_wr = wr && (addr == A_CNT);
    assign top_wr = wr && (addr == A_TOP);

`ifdef PWM_CENTER_EN
    localparam logic [AW-1:0] A_MODE = AW'(2);

    // dir_q: 0 = counting up, 1 = counting down
    logic mode_sh_q, mode_act_q, dir_q, dir_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sh_q  <= 1'b0;
            mode_act_q <= 1'b0;
            dir_q      <= 1'b0;
        end else begin
            if (period_end) mode_act_q <= mode_sh_q;
            if (wr && (addr == A_MODE)) mode_sh_q <= wdata[0];
            dir_q <= dir_d;
        end
    end
`endif

    always_comb begin
        boundary = (cnt_q >= top_act_q);
`ifdef PWM_CENTER_EN
        if (mode_act_q) boundary = (cnt_q > top_act_q) || ((cnt_q == '0) && dir_q);
`endif
    end

    assign period_end = en && !cnt_wr && boundary;

`ifdef PWM_CENTER_EN
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (cnt_wr) begin
            cnt_d = wdata;
            dir_d = 1'b0;
        end else if (period_end) begin
            dir_d = 1'b0;
            // A centre-mode valley sample is already the 0 of the new period, so resume at 1.
            cnt_d = (mode_act_q && (cnt_q <= top_act_q)) ? WIDTH'(1) : '0;
        end else if (en) begin
            if (!mode_act_q || (!dir_q && (cnt_q != top_act_q))) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else if (!dir_q) begin
                dir_d = 1'b1;
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - WIDTH'(1);
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end
`else
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_wr)          cnt_d = wdata;
        else if (period_end) cnt_d = '0;
        else if (en)         cnt_d = cnt_q + WIDTH'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            top_sh_q  <= '1;
            top_act_q <= '1;
        end else begin
            cnt_q <= cnt_d;
            if (period_end) top_act_q <= top_sh_q;
            if (top_wr)     top_sh_q  <= wdata;
        end
    end

    assign cnt = cnt_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign cmp_wr[g] = wr && (addr == AW'(g + 3));

        pwm_chan #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_i    (cmp_wr[g]),
            .wdata_i (wdata),
            .xfer_i  (period_end),
            .cnt_i   (cnt_q),
            .out_o   (out[g])
        );
    end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: 16-bit/4-channel instance plus an 8-bit/8-channel one.
// Centre-mode checks are built only when PWM_CENTER_EN is defined.

module tb_pwm_multi_channel;
    localparam logic [2:0] A_TOP = 3'd0, A_CNT = 3'd1, A_MODE = 3'd2, A_C0 = 3'd3;

    logic        clk = 1'b0;
    logic        rst_n, en, wr;
    logic [2:0]  addr;
    logic [15:0] wdata, cnt;
    logic [3:0]  pout;
    logic        pe;

    logic        en8, wr8;
    logic [3:0]  addr8;
    logic [7:0]  wdata8, cnt8, out8;
    logic        pe8;

    always #5 clk = ~clk;

    pwm_multi_channel #(.WIDTH(16), .CHANNELS(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
        .cnt(cnt), .out(pout), .period_end(pe)
    );

    pwm_multi_channel #(.WIDTH(8), .CHANNELS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .en(en8), .wr(wr8), .addr(addr8), .wdata(wdata8),
        .cnt(cnt8), .out(out8), .period_end(pe8)
    );

    typedef struct packed {
        logic [15:0] cnt;
        logic [3:0]  out;
        logic        pe;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] oexp(input logic [15:0] c, input logic [15:0] m0,
                                        input logic [15:0] m1, input logic [15:0] m2,
                                        input logic [15:0] m3);
        return {c < m3, c < m2, c < m1, c < m0};
    endfunction

    // One clock: drive write inputs, queue the expected outputs for this cycle, check at negedge.
    task automatic cyc(input string tag, input logic w, input logic [2:0] a, input logic [15:0] d,
                       input logic [15:0] ec, input logic [3:0] eo, input logic ep);
        exp_t e;
        wr = w; addr = a; wdata = d;
        sb_q.push_back('{ec, eo, ep});
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, " cnt"}, 32'(cnt), 32'(e.cnt));
        chk({tag, " out"}, 32'(pout), 32'(e.out));
        chk({tag, " pe"}, 32'(pe), 32'(e.pe));
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic setw(input logic [2:0] a, input logic [15:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic setw8(input logic [3:0] a, input logic [7:0] d);
        wr8 = 1'b1; addr8 = a; wdata8 = d;
        @(posedge clk); #1;
        wr8 = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c, dty;
        logic        w;
        logic [2:0]  a;
        logic [15:0] d;
        int          hi [8];
        int          pecnt;

        rst_n = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        en8 = 1'b0; wr8 = 1'b0; addr8 = '0; wdata8 = '0;

        // reset state
        cyc("rst", 1'b0, A_TOP, 16'd0, 16'd0, 4'd0, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;

        // async reset mid-count, no clock edge in between
        setw(A_CNT, 16'd37);
        cyc("t1 pre", 1'b0, A_TOP, 16'd0, 16'd37, 4'd0, 1'b0);
        #1 chk("t1 running", 32'(cnt), 32'd38);
        #1 rst_n = 1'b0;
        #1;
        chk("t1 async cnt", 32'(cnt), 32'd0);
        chk("t1 async out", 32'(pout), 32'd0);
        chk("t1 async pe", 32'(pe), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b0;

        // edge PWM: TOP=9, CMP = 3,0,10,5
        setw(A_TOP, 16'd9);
        setw(A_C0, 16'd3);
        setw(A_C0 + 3'd1, 16'd0);
        setw(A_C0 + 3'd2, 16'd10);
        setw(A_C0 + 3'd3, 16'd5);
        setw(A_CNT, 16'hFFFF);
        en = 1'b1;
        cyc("t2 wrap", 1'b0, A_TOP, 16'd0, 16'hFFFF, 4'd0, 1'b1);
        for (int k = 0; k < 30; k++) begin
            c = 16'(k % 10);
            cyc($sformatf("t2 k%0d", k), 1'b0, A_TOP, 16'd0, c, oexp(c, 16'd3, 16'd0, 16'd10, 16'd5),
                c == 16'd9);
        end

        // shadowing: mid-period write, period_end-cycle write, unmapped write
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 10; k++) begin
                c   = 16'(k);
                dty = (p == 0) ? 16'd3 : (p == 3) ? 16'd2 : 16'd7;
                w   = 1'b0; a = A_TOP; d = 16'd0;
                if (p == 0 && k == 4) begin w = 1'b1; a = A_C0; d = 16'd7; end
                if (p == 1 && k == 9) begin w = 1'b1; a = A_C0; d = 16'd2; end
                if (p == 2 && k == 2) begin w = 1'b1; a = 3'd7; d = 16'd0; end
                cyc($sformatf("t3 p%0d k%0d", p, k), w, a, d, c,
                    oexp(c, dty, 16'd0, 16'd10, 16'd5), c == 16'd9);
            end
        end

        // enable hold and CNT writes
        for (int k = 0; k < 5; k++) begin
            c = 16'(k);
            cyc("t4 run", 1'b0, A_TOP, 16'd0, c, oexp(c, 16'd2, 16'd0, 16'd10, 16'd5), 1'b0);
        end
        en = 1'b0;
        for (int k = 0; k < 20; k++)
            cyc($sformatf("t4 hold%0d", k), 1'b0, A_TOP, 16'd0, 16'd5,
                oexp(16'd5, 16'd2, 16'd0, 16'd10, 16'd5), 1'b0);
        en = 1'b1;
        for (int k = 5; k < 9; k++) begin
            c = 16'(k);
            cyc("t4 resume", 1'b0, A_TOP, 16'd0, c, oexp(c, 16'd2, 16'd0, 16'd10, 16'd5), 1'b0);
        end
        cyc("t4 cntwr at top", 1'b1, A_CNT, 16'd3, 16'd9,
            oexp(16'd9, 16'd2, 16'd0, 16'd10, 16'd5), 1'b0);
        cyc("t4 cntwr 200", 1'b1, A_CNT, 16'd200, 16'd3,
            oexp(16'd3, 16'd2, 16'd0, 16'd10, 16'd5), 1'b0);
        cyc("t4 over top", 1'b0, A_TOP, 16'd0, 16'd200, 4'd0, 1'b1);
        cyc("t4 wrapped", 1'b0, A_TOP, 16'd0, 16'd0, 4'b1101, 1'b0);

`ifdef PWM_CENTER_EN
        // centre-aligned: TOP=4, CMP = 2,0,0,5
        en = 1'b0;
        setw(A_MODE, 16'd1);
        setw(A_TOP, 16'd4);
        setw(A_C0, 16'd2);
        setw(A_C0 + 3'd1, 16'd0);
        setw(A_C0 + 3'd2, 16'd0);
        setw(A_C0 + 3'd3, 16'd5);
        setw(A_CNT, 16'hFFFF);
        en = 1'b1;
        cyc("t5 enter", 1'b0, A_TOP, 16'd0, 16'hFFFF, 4'd0, 1'b1);
        for (int j = 0; j < 25; j++) begin
            c = ((j % 8) <= 4) ? 16'(j % 8) : 16'(8 - (j % 8));
            cyc($sformatf("t5 j%0d", j), 1'b0, A_TOP, 16'd0, c,
                oexp(c, 16'd2, 16'd0, 16'd0, 16'd5), (c == 16'd0) && (j > 0));
        end
`endif
        en = 1'b0;

        // 8-bit / 8-channel instance: duty of channel i is 32*i / 256
        setw8(4'd0, 8'd255);
        for (int i = 0; i < 8; i++) setw8(4'(i + 3), 8'(32 * i));
        setw8(4'd1, 8'd255);
        en8 = 1'b1;
        @(negedge clk);
        chk("t6 wrap pe", 32'(pe8), 32'd1);
        chk("t6 wrap cnt", 32'(cnt8), 32'd255);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) hi[i] = 0;
        pecnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) hi[i] += int'(out8[i]);
            pecnt += int'(pe8);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 8; i++) chk($sformatf("t6 duty ch%0d", i), 32'(hi[i]), 32'(32 * i));
        chk("t6 pe count", 32'(pecnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
